unsigned_divide_seq: RTL and testbench

//  Multi-cycle unsigned restoring divider; the inverse datapath of the unsigned_multiply testcase.

---
 rtl/unsigned_divide_seq_pkg.sv | 14 +
 rtl/unsigned_divide_seq_if.sv | 28 ++
 rtl/unsigned_divide_seq_div_step.sv | 29 ++
 rtl/unsigned_divide_seq.sv | 114 +++++++++++
 tb/tb_unsigned_divide_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/unsigned_divide_seq_pkg.sv
// Shared types and default widths for the sequential unsigned divider.
//   div_state_t     : FSM state encoding (IDLE, CALC, DONE)
//   DEF_DIVISOR_W   : default divisor/remainder width
//   DEF_DIVIDEND_W  : default dividend/quotient width (2x divisor)
//   DEF_COUNT_W     : step counter width at default widths
package unsigned_divide_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   localparam int unsigned DEF_DIVISOR_W  = 5;
   localparam int unsigned DEF_DIVIDEND_W = 2 * DEF_DIVISOR_W;
   localparam int unsigned DEF_COUNT_W    = $clog2(DEF_DIVIDEND_W);

endpackage

// File: rtl/unsigned_divide_seq_if.sv
// Handshake and data bundle for unsigned_divide_seq.
//   start, dataa (2W), datab (W)              : request side, driven by master
//   busy, done, quotient (2W), remainder (W),
//   div_by_zero                               : result side, driven by slave (the divider)
interface unsigned_divide_seq_if
   import unsigned_divide_pkg::*;
#(
   parameter int unsigned DIVISOR_W = DEF_DIVISOR_W
);
   logic                     start;
   logic [2*DIVISOR_W-1:0]   dataa;
   logic [DIVISOR_W-1:0]     datab;
   logic                     busy;
   logic                     done;
   logic [2*DIVISOR_W-1:0]   quotient;
   logic [DIVISOR_W-1:0]     remainder;
   logic                     div_by_zero;

   modport master (
      output start, dataa, datab,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dataa, datab,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/unsigned_divide_seq_div_step.sv
// One restoring-division step (combinational).
//   r        in  W+1  partial remainder (always < divisor, so top bit is 0)
//   dbit     in  1    next dividend bit shifted into the remainder
//   divisor  in  W    divisor
//   r_next   out W+1  updated partial remainder
//   q_bit    out 1    resolved quotient bit
module div_step
   import unsigned_divide_pkg::*;
#(
   parameter int unsigned DIVISOR_W = DEF_DIVISOR_W
) (
   input  logic [DIVISOR_W:0]   r,
   input  logic                 dbit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   r_next,
   output logic                 q_bit
);
   // Shift the whole of r so every bit is consumed; r[W] is 0 by construction so
   // this equals {r[W-1:0], dbit} zero-extended.
   logic [DIVISOR_W+1:0] r_shift;
   logic [DIVISOR_W+1:0] div_ext;

   always_comb begin
      r_shift = {r, dbit};
      div_ext = (DIVISOR_W + 2)'(divisor);
      q_bit   = (r_shift >= div_ext);
      r_next  = q_bit ? (DIVISOR_W + 1)'(r_shift - div_ext) : (DIVISOR_W + 1)'(r_shift);
   end
endmodule

// File: rtl/unsigned_divide_seq.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock under a start/busy/done handshake.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of unsigned_divide_seq_if (start/dataa/datab in;
//        busy/done/quotient/remainder/div_by_zero out)
module unsigned_divide_seq
   import unsigned_divide_pkg::*;
#(
   parameter int unsigned DIVISOR_W = DEF_DIVISOR_W
) (
   input logic                  clk,
   input logic                  rst,
   unsigned_divide_seq_if.slave bus
);
   localparam int unsigned DW   = 2 * DIVISOR_W;
   localparam int unsigned CW   = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   div_state_t             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   // Dividend shifts out at the top while quotient bits shift in at the bottom.
   logic [DW-1:0]          dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]   dvs_q, dvs_d;
   logic [DIVISOR_W:0]     r_q, r_d;
   logic [DW-1:0]          quo_q, quo_d;
   logic [DIVISOR_W-1:0]   rem_q, rem_d;
   logic                   dbz_q, dbz_d;

   logic [DIVISOR_W:0]     r_next;
   logic                   q_bit;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .r       (r_q),
      .dbit    (dvd_q[DW-1]),
      .divisor (dvs_q),
      .r_next  (r_next),
      .q_bit   (q_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               if (bus.datab == '0) begin
                  // Divide by zero resolves immediately without entering CALC.
                  state_d = DONE;
                  quo_d   = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  dvd_d   = bus.dataa;
                  dvs_d   = bus.datab;
                  r_d     = '0;
                  cnt_d   = '0;
               end
            end
         end
         CALC: begin
            dvd_d = {dvd_q[DW-2:0], q_bit};
            r_d   = r_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               quo_d   = {dvd_q[DW-2:0], q_bit};
               rem_d   = r_next[DIVISOR_W-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == CALC);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_unsigned_divide_seq.sv
// Directed and random checks for unsigned_divide_seq at the default width (W=5).
module tb_unsigned_divide_seq;
   localparam int unsigned W  = 5;
   localparam int unsigned DW = 2 * W;

   typedef struct {
      logic [DW-1:0] a;
      logic [W-1:0]  b;
      logic [DW-1:0] q;
      logic [W-1:0]  r;
      logic          dbz;
      int            lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   unsigned_divide_seq_if #(.DIVISOR_W(W)) bus ();

   unsigned_divide_seq #(.DIVISOR_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present a request for one cycle; s returns the cycle count just after the accepting edge.
   task automatic issue(input logic [DW-1:0] a, input logic [W-1:0] b, output int s);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dataa = a;
      bus.datab = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      s = cyc;
   endtask

   task automatic wait_done(input int s, output int lat);
      while (bus.done !== 1'b1 && (cyc - s) < 40) begin
         @(posedge clk);
         #1;
      end
      lat = cyc - s;
   endtask

   task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [W-1:0] b,
                         input logic [DW-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat);
      int s, lat;
      issue(a, b, s);
      check({tag, ".busy"}, 32'(bus.busy), 32'(b != '0));
      wait_done(s, lat);
      check({tag, ".latency"}, 32'(lat), 32'(elat));
      check({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
      check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
      check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
   endtask

   vec_t vecs[9];

   initial begin
      int s, lat, seen;
      logic [DW-1:0] ra, gq;
      logic [W-1:0]  rb, gr;

      vecs[0] = '{a: 10'd1000, b: 5'd7,  q: 10'd142,  r: 5'd6,  dbz: 1'b0, lat: 10};
      vecs[1] = '{a: 10'd1023, b: 5'd31, q: 10'd33,   r: 5'd0,  dbz: 1'b0, lat: 10};
      vecs[2] = '{a: 10'd3,    b: 5'd17, q: 10'd0,    r: 5'd3,  dbz: 1'b0, lat: 10};
      vecs[3] = '{a: 10'd5,    b: 5'd0,  q: 10'd1023, r: 5'd0,  dbz: 1'b1, lat: 0};
      vecs[4] = '{a: 10'd600,  b: 5'd25, q: 10'd24,   r: 5'd0,  dbz: 1'b0, lat: 10};
      vecs[5] = '{a: 10'd1023, b: 5'd1,  q: 10'd1023, r: 5'd0,  dbz: 1'b0, lat: 10};
      vecs[6] = '{a: 10'd0,    b: 5'd5,  q: 10'd0,    r: 5'd0,  dbz: 1'b0, lat: 10};
      vecs[7] = '{a: 10'd512,  b: 5'd31, q: 10'd16,   r: 5'd16, dbz: 1'b0, lat: 10};
      vecs[8] = '{a: 10'd999,  b: 5'd30, q: 10'd33,   r: 5'd9,  dbz: 1'b0, lat: 10};

      bus.start = 1'b0;
      bus.dataa = '0;
      bus.datab = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      check("reset.quotient", 32'(bus.quotient), 32'd0);
      check("reset.remainder", 32'(bus.remainder), 32'd0);
      check("reset.div_by_zero", 32'(bus.div_by_zero), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                vecs[i].dbz, vecs[i].lat);
         repeat (2) @(posedge clk);
      end

      // Start pulsed during CALC must be ignored.
      issue(10'd1000, 5'd7, s);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dataa = 10'd50;
      bus.datab = 5'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("ignore.busy", 32'(bus.busy), 32'd1);
      check("ignore.held_quotient", 32'(bus.quotient), 32'd999 / 32'd30);
      wait_done(s, lat);
      check("ignore.latency", 32'(lat), 32'd10);
      check("ignore.quotient", 32'(bus.quotient), 32'd142);
      check("ignore.remainder", 32'(bus.remainder), 32'd6);
      repeat (2) @(posedge clk);

      // Reset mid-CALC aborts: outputs clear at once and no done follows.
      issue(10'd1000, 5'd7, s);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort.busy", 32'(bus.busy), 32'd0);
      check("abort.done", 32'(bus.done), 32'd0);
      check("abort.quotient", 32'(bus.quotient), 32'd0);
      check("abort.remainder", 32'(bus.remainder), 32'd0);
      check("abort.div_by_zero", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen = 1;
      end
      check("abort.no_done", 32'(seen), 32'd0);
      run_op("after_abort", 10'd600, 5'd25, 10'd24, 5'd0, 1'b0, 10);

      // Random operands, each issued back-to-back in the previous DONE cycle.
      for (int i = 0; i < 100; i++) begin
         ra = DW'($urandom_range(0, (1 << DW) - 1));
         rb = (i % 17 == 5) ? '0 : W'($urandom_range(0, (1 << W) - 1));
         if (rb == '0) begin
            gq = '1;
            gr = '0;
         end else begin
            gq = ra / DW'(rb);
            gr = W'(ra % DW'(rb));
         end
         run_op($sformatf("rnd%0d", i), ra, rb, gq, gr, rb == '0, (rb == '0) ? 0 : 10);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
